branch_resolver: RTL and testbench

- Resolution end of the branch-prediction loop in the multi-cycle TSC CPU.
- Fetch side: records each conditional-branch prediction taken from the 2-bit predictor in an in-order queue.
- Execute side: compares each actual outcome with the oldest queued prediction.
  - Correct prediction: issues the predictor's reinforce pulse (call_bp).
  - Misprediction: issues the recovery pulse (bubble) plus a pipeline flush and a PC redirect.

---
 rtl/branch_resolver.sv | 207 ++++++++++++++++++++
 tb/tb_branch_resolver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolver
//  Purpose  : Resolution end of the branch-prediction loop. Conditional-branch
//             predictions are recorded in an in-order queue at fetch; each
//             execute-stage outcome is compared with the oldest prediction.
//             A correct prediction pulses call_bp (predictor reinforce); a
//             wrong one pulses bubble + flush, presents redirect_pc, clears
//             the queue and holds fetch for RECOVER_CYCLES cycles.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk               in   clock, all state on posedge
//    reset             in   asynchronous active-high reset
//    fetch_branch      in   fetch issued a conditional branch
//    predicted_taken   in   predictor output qualified by fetch_branch
//    fetch_target      in   branch target PC
//    fetch_fallthrough in   PC+1 of the branch
//    resolve_valid     in   execute resolved the oldest branch
//    actual_taken      in   real outcome, qualified by resolve_valid
//    call_bp           out  1-cycle pulse: prediction correct
//    bubble            out  1-cycle pulse: mispredict recovery step
//    flush             out  1-cycle pulse: squash wrong-path instructions
//    redirect_pc       out  correct PC, valid while flush=1
//    stall_fetch       out  queue full or recovering
//    outstanding       out  queue occupancy (0..DEPTH)
//    num_branches      out  saturating resolved-branch count
//    num_mispredicts   out  saturating mispredict count
//    err_underflow     out  sticky: resolve arrived with empty queue
// ============================================================================
module branch_resolver #(
    parameter int WORD_SIZE      = 16,
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_branch,
    input  logic                     predicted_taken,
    input  logic [WORD_SIZE-1:0]     fetch_target,
    input  logic [WORD_SIZE-1:0]     fetch_fallthrough,
    input  logic                     resolve_valid,
    input  logic                     actual_taken,
    output logic                     call_bp,
    output logic                     bubble,
    output logic                     flush,
    output logic [WORD_SIZE-1:0]     redirect_pc,
    output logic                     stall_fetch,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic [CNT_W-1:0]         num_branches,
    output logic [CNT_W-1:0]         num_mispredicts,
    output logic                     err_underflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;
    localparam int c_RC_W  = $clog2(RECOVER_CYCLES + 1);

    localparam logic [c_OCC_W-1:0] c_DEPTH   = c_OCC_W'(DEPTH);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_RC_W-1:0]  c_RC_LOAD = c_RC_W'(RECOVER_CYCLES);
    localparam logic [c_RC_W-1:0]  c_RC_ONE  = c_RC_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

    localparam logic [0:0] c_ST_RUN     = 1'b0;
    localparam logic [0:0] c_ST_RECOVER = 1'b1;

    // Queue storage: predicted direction plus the PC to use if it was wrong.
    logic                 r_q_pred [DEPTH];
    logic [WORD_SIZE-1:0] r_q_alt  [DEPTH];

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_OCC_W-1:0]   r_count;
    logic [0:0]           r_state;
    logic [c_RC_W-1:0]    r_rc_cnt;

    logic                 r_call_bp;
    logic                 r_bubble;
    logic                 r_flush;
    logic [WORD_SIZE-1:0] r_redirect_pc;
    logic [CNT_W-1:0]     r_num_branches;
    logic [CNT_W-1:0]     r_num_mispredicts;
    logic                 r_err_underflow;

    logic                 w_run;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_res;
    logic                 w_mis;
    logic                 w_correct;
    logic                 w_push;
    logic                 w_underflow;
    logic                 w_head_pred;
    logic [WORD_SIZE-1:0] w_head_alt;

    always_comb begin
        w_run       = (r_state == c_ST_RUN);
        w_full      = (r_count == c_DEPTH);
        w_empty     = (r_count == '0);
        w_head_pred = r_q_pred[r_rd_ptr];
        w_head_alt  = r_q_alt[r_rd_ptr];
        w_res       = resolve_valid & w_run & ~w_empty;
        w_mis       = w_res & (w_head_pred != actual_taken);
        w_correct   = w_res & ~w_mis;
        w_underflow = resolve_valid & w_run & w_empty;
        // A full queue still accepts a branch when a correct resolve frees a
        // slot in the same cycle. A mispredict discards the incoming entry
        // because it is on the wrong path.
        w_push      = fetch_branch & w_run & (~w_full | w_correct) & ~w_mis;
    end

    // Storage carries no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pred[r_wr_ptr] <= predicted_taken;
            r_q_alt[r_wr_ptr]  <= predicted_taken ? fetch_fallthrough : fetch_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_count           <= '0;
            r_state           <= c_ST_RUN;
            r_rc_cnt          <= '0;
            r_call_bp         <= 1'b0;
            r_bubble          <= 1'b0;
            r_flush           <= 1'b0;
            r_redirect_pc     <= '0;
            r_num_branches    <= '0;
            r_num_mispredicts <= '0;
            r_err_underflow   <= 1'b0;
        end else begin
            r_call_bp <= w_correct;
            r_bubble  <= w_mis;
            r_flush   <= w_mis;
            if (w_mis) begin
                r_redirect_pc <= w_head_alt;
            end

            if (w_res && (r_num_branches != c_CNT_MAX)) begin
                r_num_branches <= r_num_branches + c_CNT_ONE;
            end
            if (w_mis && (r_num_mispredicts != c_CNT_MAX)) begin
                r_num_mispredicts <= r_num_mispredicts + c_CNT_ONE;
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end

            case (r_state)
                c_ST_RUN: begin
                    if (w_mis) begin
                        r_state  <= c_ST_RECOVER;
                        r_rc_cnt <= c_RC_LOAD;
                    end
                end
                c_ST_RECOVER: begin
                    // Leaving on the count of one makes RECOVER last exactly
                    // RECOVER_CYCLES cycles including the flush cycle.
                    if (r_rc_cnt == c_RC_ONE) begin
                        r_state <= c_ST_RUN;
                    end
                    r_rc_cnt <= r_rc_cnt - c_RC_ONE;
                end
                default: begin
                    r_state <= c_ST_RUN;
                end
            endcase

            if (w_mis) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_res) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_push && !w_res) begin
                    r_count <= r_count + c_OCC_ONE;
                end else if (!w_push && w_res) begin
                    r_count <= r_count - c_OCC_ONE;
                end
            end
        end
    end

    assign call_bp         = r_call_bp;
    assign bubble          = r_bubble;
    assign flush           = r_flush;
    assign redirect_pc     = r_redirect_pc;
    assign stall_fetch     = w_full | (r_state == c_ST_RECOVER);
    assign outstanding     = r_count;
    assign num_branches    = r_num_branches;
    assign num_mispredicts = r_num_mispredicts;
    assign err_underflow   = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolver
//  Purpose  : Self-checking bench for branch_resolver. Directed vector table,
//             hand-written reset/saturation sequences and a randomized run
//             against a queue-based reference model. A second instance with
//             4-bit counters exercises saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolver;

    localparam int WS    = 16;
    localparam int DEPTH = 4;
    localparam int RC    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_branch = 1'b0;
    logic          predicted_taken = 1'b0;
    logic [WS-1:0] fetch_target = '0;
    logic [WS-1:0] fetch_fallthrough = '0;
    logic          resolve_valid = 1'b0;
    logic          actual_taken = 1'b0;

    logic          call_bp, bubble, flush, stall_fetch, err_underflow;
    logic [WS-1:0] redirect_pc;
    logic [2:0]    outstanding;
    logic [15:0]   num_branches, num_mispredicts;

    logic          s_call_bp, s_bubble, s_flush, s_stall_fetch, s_err_underflow;
    logic [WS-1:0] s_redirect_pc;
    logic [2:0]    s_outstanding;
    logic [3:0]    s_num_branches, s_num_mispredicts;

    branch_resolver #(.WORD_SIZE(WS), .DEPTH(DEPTH), .RECOVER_CYCLES(RC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .fetch_branch(fetch_branch),
        .predicted_taken(predicted_taken), .fetch_target(fetch_target),
        .fetch_fallthrough(fetch_fallthrough), .resolve_valid(resolve_valid),
        .actual_taken(actual_taken), .call_bp(call_bp), .bubble(bubble),
        .flush(flush), .redirect_pc(redirect_pc), .stall_fetch(stall_fetch),
        .outstanding(outstanding), .num_branches(num_branches),
        .num_mispredicts(num_mispredicts), .err_underflow(err_underflow)
    );

    branch_resolver #(.WORD_SIZE(WS), .DEPTH(DEPTH), .RECOVER_CYCLES(RC), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .fetch_branch(fetch_branch),
        .predicted_taken(predicted_taken), .fetch_target(fetch_target),
        .fetch_fallthrough(fetch_fallthrough), .resolve_valid(resolve_valid),
        .actual_taken(actual_taken), .call_bp(s_call_bp), .bubble(s_bubble),
        .flush(s_flush), .redirect_pc(s_redirect_pc), .stall_fetch(s_stall_fetch),
        .outstanding(s_outstanding), .num_branches(s_num_branches),
        .num_mispredicts(s_num_mispredicts), .err_underflow(s_err_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          pred;
        logic [WS-1:0] alt;
    } ent_t;

    ent_t          mq[$];
    int            m_rec;
    logic          m_call, m_bub, m_flush, m_err;
    logic [WS-1:0] m_redir;
    int            m_nb, m_nm, m_nb4, m_nm4;

    function automatic void model_reset();
        mq.delete();
        m_rec = 0; m_call = 0; m_bub = 0; m_flush = 0; m_err = 0;
        m_redir = '0; m_nb = 0; m_nm = 0; m_nb4 = 0; m_nm4 = 0;
    endfunction

    function automatic void model_step(input logic fb, input logic pt, input logic [WS-1:0] tgt,
                                       input logic [WS-1:0] ft, input logic rv, input logic at);
        ent_t head;
        ent_t e;
        bit   res, mis, enq;
        m_call = 0; m_bub = 0; m_flush = 0;
        if (m_rec > 0) begin
            m_rec--;
            return;
        end
        res = rv && (mq.size() > 0);
        if (rv && mq.size() == 0) m_err = 1;
        mis = res && (mq[0].pred != at);
        enq = fb && ((mq.size() < DEPTH) || (res && !mis));
        if (res) begin
            head = mq.pop_front();
            m_nb  = (m_nb  < 65535) ? m_nb + 1  : m_nb;
            m_nb4 = (m_nb4 < 15)    ? m_nb4 + 1 : m_nb4;
            if (mis) begin
                m_nm  = (m_nm  < 65535) ? m_nm + 1  : m_nm;
                m_nm4 = (m_nm4 < 15)    ? m_nm4 + 1 : m_nm4;
                mq.delete();
                m_bub = 1; m_flush = 1; m_redir = head.alt; m_rec = RC;
            end else begin
                m_call = 1;
            end
        end
        if (enq && !mis) begin
            e.pred = pt;
            e.alt  = pt ? ft : tgt;
            mq.push_back(e);
        end
    endfunction

    task automatic model_check(input string tag);
        chk({tag, ".call_bp"}, call_bp, m_call);
        chk({tag, ".bubble"}, bubble, m_bub);
        chk({tag, ".flush"}, flush, m_flush);
        if (m_flush) chk({tag, ".redirect_pc"}, redirect_pc, m_redir);
        chk({tag, ".stall"}, stall_fetch, (mq.size() == DEPTH) || (m_rec > 0));
        chk({tag, ".outstanding"}, outstanding, mq.size());
        chk({tag, ".num_br"}, num_branches, m_nb);
        chk({tag, ".num_mis"}, num_mispredicts, m_nm);
        chk({tag, ".err"}, err_underflow, m_err);
        chk({tag, ".num_br4"}, s_num_branches, m_nb4);
        chk({tag, ".num_mis4"}, s_num_mispredicts, m_nm4);
    endtask

    // Drive one cycle, advance model at the edge, leave time at edge+1.
    task automatic cyc(input logic fb, input logic pt, input logic [WS-1:0] tgt,
                       input logic [WS-1:0] ft, input logic rv, input logic at);
        fetch_branch = fb; predicted_taken = pt; fetch_target = tgt;
        fetch_fallthrough = ft; resolve_valid = rv; actual_taken = at;
        @(posedge clk);
        model_step(fb, pt, tgt, ft, rv, at);
        #1;
        fetch_branch = 0; resolve_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          fb, pt;
        logic [WS-1:0] tgt, ft;
        logic          rv, at;
        logic          e_call, e_bub, e_flush;
        logic [WS-1:0] e_redir;
        logic          e_stall;
        int            e_out, e_nb, e_nm;
        logic          e_err;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           fb pt tgt      ft       rv at  call bub fl redir    st out nb nm err
        tbl[0]  = '{1, 1, 16'h0040, 16'h0011, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 0};
        tbl[2]  = '{1, 1, 16'h0040, 16'h0011, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0};
        tbl[3]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, 16'h0011, 1, 0, 2, 1, 0};
        tbl[4]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 2, 1, 0};
        tbl[5]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 2, 1, 0};
        tbl[6]  = '{1, 0, 16'h0100, 16'h0200, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 2, 1, 0};
        tbl[7]  = '{1, 0, 16'h0101, 16'h0201, 0, 0, 0, 0, 0, 16'h0000, 0, 2, 2, 1, 0};
        tbl[8]  = '{1, 0, 16'h0102, 16'h0202, 0, 0, 0, 0, 0, 16'h0000, 0, 3, 2, 1, 0};
        tbl[9]  = '{1, 0, 16'h0103, 16'h0203, 0, 0, 0, 0, 0, 16'h0000, 1, 4, 2, 1, 0};
        tbl[10] = '{1, 1, 16'h0104, 16'h0204, 0, 0, 0, 0, 0, 16'h0000, 1, 4, 2, 1, 0};
        tbl[11] = '{1, 0, 16'h0104, 16'h0204, 1, 0, 1, 0, 0, 16'h0000, 1, 4, 3, 1, 0};
        tbl[12] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 0, 3, 4, 1, 0};
        tbl[13] = '{1, 0, 16'h0105, 16'h0205, 1, 1, 0, 1, 1, 16'h0102, 1, 0, 5, 2, 0};
        tbl[14] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 5, 2, 0};
        tbl[15] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 5, 2, 0};
        tbl[16] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 5, 2, 1};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.call_bp", call_bp, 0);
        chk("rst.bubble", bubble, 0);
        chk("rst.flush", flush, 0);
        chk("rst.redirect_pc", redirect_pc, 0);
        chk("rst.stall", stall_fetch, 0);
        chk("rst.outstanding", outstanding, 0);
        chk("rst.num_br", num_branches, 0);
        chk("rst.num_mis", num_mispredicts, 0);
        chk("rst.err", err_underflow, 0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].fb, tbl[i].pt, tbl[i].tgt, tbl[i].ft, tbl[i].rv, tbl[i].at);
            chk($sformatf("tbl%0d.call_bp", i), call_bp, tbl[i].e_call);
            chk($sformatf("tbl%0d.bubble", i), bubble, tbl[i].e_bub);
            chk($sformatf("tbl%0d.flush", i), flush, tbl[i].e_flush);
            if (tbl[i].e_flush) chk($sformatf("tbl%0d.redirect_pc", i), redirect_pc, tbl[i].e_redir);
            chk($sformatf("tbl%0d.stall", i), stall_fetch, tbl[i].e_stall);
            chk($sformatf("tbl%0d.outstanding", i), outstanding, tbl[i].e_out);
            chk($sformatf("tbl%0d.num_br", i), num_branches, tbl[i].e_nb);
            chk($sformatf("tbl%0d.num_mis", i), num_mispredicts, tbl[i].e_nm);
            chk($sformatf("tbl%0d.err", i), err_underflow, tbl[i].e_err);
            model_check($sformatf("tbl%0d.model", i));
        end

        // Asynchronous reset while recovering
        do_reset();
        cyc(1, 1, 16'h0300, 16'h0301, 0, 0);
        cyc(1, 1, 16'h0310, 16'h0311, 0, 0);
        cyc(0, 0, 16'h0000, 16'h0000, 1, 0);
        model_check("arst.pre");
        #2;
        reset = 1'b1;
        #1;
        chk("arst.call_bp", call_bp, 0);
        chk("arst.bubble", bubble, 0);
        chk("arst.flush", flush, 0);
        chk("arst.redirect_pc", redirect_pc, 0);
        chk("arst.stall", stall_fetch, 0);
        chk("arst.outstanding", outstanding, 0);
        chk("arst.num_br", num_branches, 0);
        chk("arst.num_mis", num_mispredicts, 0);
        chk("arst.err", err_underflow, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1, 0, 16'h0400, 16'h0401, 0, 0);
        chk("arst.enq_after", outstanding, 1);
        model_check("arst.post");

        // Counter saturation on the 4-bit instance
        do_reset();
        cyc(1, 1, 16'h0500, 16'h0501, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 16'h0500, 16'h0501, 1, 1);
            model_check($sformatf("sat%0d", i));
        end
        chk("sat.num_br4", s_num_branches, 15);
        chk("sat.num_br16", num_branches, 20);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic          fb, pt, rv, at;
            logic [WS-1:0] tgt, ft;
            fb  = ($urandom_range(0, 99) < 55);
            pt  = $urandom_range(0, 1);
            tgt = WS'($urandom);
            ft  = WS'($urandom);
            rv  = ($urandom_range(0, 99) < 40);
            at  = ($urandom_range(0, 99) < 70) ? pt_head_guess(pt) : ~pt_head_guess(pt);
            cyc(fb, pt, tgt, ft, rv, at);
            model_check($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bias outcomes toward the queued head prediction so correct resolves,
    // mispredicts and full-queue conditions all occur frequently.
    function automatic logic pt_head_guess(input logic dflt);
        if (mq.size() > 0) return mq[0].pred;
        return dflt;
    endfunction

endmodule
`default_nettype wire
